// File: rtl/rv_mem_arbiter_pkg.sv
// Shared definitions for the fetch/LSU unified memory arbiter.
// Port tag encodings, in-flight tag layout and address width helper.
package rv_mem_arbiter_pkg;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic err;
        logic we;
    } tag_t;

    function automatic int word_aw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// Request/response and memory-side bundle of the unified memory arbiter.
// master = core front-end, LSU and memory array; slave = arbiter.
interface rv_mem_arbiter_if
    import rv_mem_arbiter_pkg::*;
#(
    parameter int WORDS = 64
);
    localparam int AW = word_aw(WORDS);

    logic          if_req_valid;
    logic          if_req_ready;
    logic [31:0]   if_addr;
    logic          if_rsp_valid;
    logic [31:0]   if_rdata;
    logic          if_err;

    logic          ls_req_valid;
    logic          ls_req_ready;
    logic          ls_we;
    logic [31:0]   ls_addr;
    logic [31:0]   ls_wdata;
    logic [3:0]    ls_wstrb;
    logic          ls_rsp_valid;
    logic [31:0]   ls_rdata;
    logic          ls_err;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;

    modport master (
        output if_req_valid, if_addr,
        output ls_req_valid, ls_we, ls_addr, ls_wdata, ls_wstrb,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rdata, if_err,
        input  ls_req_ready, ls_rsp_valid, ls_rdata, ls_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  if_req_valid, if_addr,
        input  ls_req_valid, ls_we, ls_addr, ls_wdata, ls_wstrb,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rdata, if_err,
        output ls_req_ready, ls_rsp_valid, ls_rdata, ls_err,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/rv_prio_starve.sv
// Two-requester grant: LSU wins conflicts until fetch has lost
// STARVE_LIMIT times in a row, then fetch wins once.
module rv_prio_starve
    import rv_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt;
    logic          starved;

    assign starved = (cnt == CW'(STARVE_LIMIT));

    always_comb begin
        gnt = '0;
        if (rst) begin
            gnt = '0;
        end else if (req[PORT_LS] && !(req[PORT_IF] && starved)) begin
            gnt[PORT_LS] = 1'b1;
        end else if (req[PORT_IF]) begin
            gnt[PORT_IF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (gnt[PORT_IF]) begin
            cnt <= '0;
        end else if (req[PORT_IF] && gnt[PORT_LS] && !starved) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store.
// One grant per cycle; the tagged response returns exactly one cycle later.
module rv_mem_arbiter
    import rv_mem_arbiter_pkg::*;
#(
    parameter int WORDS        = 64,
    parameter int STARVE_LIMIT = 4
) (
    input logic             clk,
    input logic             rst,
    rv_mem_arbiter_if.slave bus
);
    localparam int          AW    = word_aw(WORDS);
    localparam logic [31:0] DEPTH = 32'(WORDS);

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [29:0] if_idx;
    logic [29:0] ls_idx;
    logic [29:0] sel_idx;
    logic        if_oor;
    logic        ls_oor;
    logic        sel_ls;
    logic        sel_err;
    tag_t        tag;
    logic        rsp_on;
    logic        rd_ok;
    logic        if_rsp;
    logic        ls_rsp;
    logic        unused_bits;

    assign req[PORT_IF] = bus.if_req_valid;
    assign req[PORT_LS] = bus.ls_req_valid;

    rv_prio_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk(clk),
        .rst(rst),
        .req(req),
        .gnt(gnt)
    );

    assign bus.if_req_ready = gnt[PORT_IF];
    assign bus.ls_req_ready = gnt[PORT_LS];

    assign if_idx  = bus.if_addr[31:2];
    assign ls_idx  = bus.ls_addr[31:2];
    assign if_oor  = {2'b00, if_idx} >= DEPTH;
    assign ls_oor  = {2'b00, ls_idx} >= DEPTH;
    assign sel_ls  = gnt[PORT_LS];
    assign sel_idx = sel_ls ? ls_idx : if_idx;
    assign sel_err = sel_ls ? ls_oor : if_oor;

    // Out-of-range requests are accepted but never reach the array.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if ((|gnt) && !sel_err) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = sel_idx[AW-1:0];
            if (sel_ls && bus.ls_we) begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = bus.ls_wdata;
                bus.mem_wstrb = bus.ls_wstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag <= '0;
        end else begin
            tag.valid <= |gnt;
            tag.port  <= sel_ls ? PORT_LS : PORT_IF;
            tag.err   <= sel_err;
            tag.we    <= sel_ls && bus.ls_we;
        end
    end

    // A response due in a reset cycle is dropped.
    assign rsp_on = tag.valid && !rst;
    assign rd_ok  = rsp_on && !tag.err && !tag.we;
    assign if_rsp = rsp_on && (tag.port == PORT_IF);
    assign ls_rsp = rsp_on && (tag.port == PORT_LS);

    assign bus.if_rsp_valid = if_rsp;
    assign bus.ls_rsp_valid = ls_rsp;
    assign bus.if_err       = if_rsp && tag.err;
    assign bus.ls_err       = ls_rsp && tag.err;
    assign bus.if_rdata     = (if_rsp && rd_ok) ? bus.mem_rdata : '0;
    assign bus.ls_rdata     = (ls_rsp && rd_ok) ? bus.mem_rdata : '0;

    assign unused_bits = ^{bus.if_addr[1:0], bus.ls_addr[1:0], sel_idx};

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Testbench for rv_mem_arbiter: vector table, directed sequences and
// randomized traffic against a transaction-level reference model.
module tb_rv_mem_arbiter;
    import rv_mem_arbiter_pkg::*;

    localparam int W  = 64;
    localparam int W2 = 2048;
    localparam int SL = 4;
    localparam int NR = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_mem = 1'b1;

    always #5 clk = ~clk;

    rv_mem_arbiter_if #(.WORDS(W))  bus ();
    rv_mem_arbiter_if #(.WORDS(W2)) bus2 ();

    rv_mem_arbiter #(.WORDS(W), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    rv_mem_arbiter #(.WORDS(W2), .STARVE_LIMIT(SL)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    logic [31:0] mem  [W];
    logic [31:0] mem2 [W2];
    logic [31:0] ref_mem [W];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < W; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b])
                        mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (bus2.mem_en) begin
            if (bus2.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus2.mem_wstrb[b])
                        mem2[bus2.mem_addr][8*b +: 8] <= bus2.mem_wdata[8*b +: 8];
            end else begin
                bus2.mem_rdata <= mem2[bus2.mem_addr];
            end
        end
    end

    int pass_n = 0;
    int total_n = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic drv_if(input logic v, input logic [31:0] a);
        bus.if_req_valid = v;
        bus.if_addr      = a;
    endtask

    task automatic drv_ls(input logic v, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws);
        bus.ls_req_valid = v;
        bus.ls_we        = we;
        bus.ls_addr      = a;
        bus.ls_wdata     = wd;
        bus.ls_wstrb     = ws;
    endtask

    task automatic drv_ls2(input logic v, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws);
        bus2.ls_req_valid = v;
        bus2.ls_we        = we;
        bus2.ls_addr      = a;
        bus2.ls_wdata     = wd;
        bus2.ls_wstrb     = ws;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return $urandom() | 32'h0000_1000;
        return 32'($urandom_range(0, W - 1)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic        lwe;
        logic [31:0] la;
        logic [31:0] lwd;
        logic [3:0]  lws;
        logic [2:0]  rdy;
        logic [2:0]  rsp;
        logic [31:0] rd;
    } vec_t;

    vec_t vt [9];

    logic        iv, lv, lwe, if_acc, ls_acc, eg_if, eg_ls;
    logic [31:0] ia, la, lwd, a;
    logic [3:0]  lws;
    logic        p_if, p_ls, p_err;
    logic [31:0] p_data;
    int          starve, idx, bad;

    initial begin
        // {if_ready, ls_ready, mem_en}, {if_rsp, ls_rsp, err}, rdata
        vt[0] = '{1'b1, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0, 4'h0,
                  3'b101, 3'b000, 32'h0};
        vt[1] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10,  32'h0, 4'h0,
                  3'b011, 3'b100, 32'hA000_0000};
        vt[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h0, 4'h0,
                  3'b010, 3'b010, 32'hA000_0004};
        vt[3] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0, 4'h0,
                  3'b100, 3'b011, 32'h0};
        vt[4] = '{1'b1, 32'h4,   1'b1, 1'b0, 32'h8,   32'h0, 4'h0,
                  3'b011, 3'b101, 32'h0};
        vt[5] = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0,   32'h0, 4'h0,
                  3'b101, 3'b010, 32'hA000_0002};
        vt[6] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0, 4'h0,
                  3'b000, 3'b100, 32'hA000_0001};
        vt[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hC, 32'h1122_3344, 4'hF,
                  3'b011, 3'b000, 32'h0};
        vt[8] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0, 4'h0,
                  3'b000, 3'b010, 32'h0};

        drv_if(1'b1, 32'h0);
        drv_ls(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
        drv_ls2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus2.if_req_valid = 1'b0;
        bus2.if_addr      = 32'h0;

        // Reset held with both valids high
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_quiet",
                {bus.if_req_ready, bus.ls_req_ready, bus.mem_en, bus.mem_we,
                 bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_err, bus.ls_err},
                32'h0);
        end
        chk("reset_rdata", bus.if_rdata | bus.ls_rdata, 32'h0);
        step();
        rst = 1'b0;
        init_mem = 1'b0;
        drv_if(1'b0, 32'h0);
        drv_ls(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        for (int i = 0; i < 9; i++) begin
            step();
            drv_if(vt[i].iv, vt[i].ia);
            drv_ls(vt[i].lv, vt[i].lwe, vt[i].la, vt[i].lwd, vt[i].lws);
            @(negedge clk);
            chk($sformatf("vec%0d_rdy", i),
                {bus.if_req_ready, bus.ls_req_ready, bus.mem_en}, vt[i].rdy);
            chk($sformatf("vec%0d_rsp", i),
                {bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_err | bus.ls_err},
                vt[i].rsp);
            chk($sformatf("vec%0d_rdata", i),
                bus.if_rdata | bus.ls_rdata, vt[i].rd);
        end
        chk("vec_store_word3", mem[3], 32'h1122_3344);

        // Fetch-only stream, no bubbles
        for (int k = 0; k < 4; k++) begin
            step();
            drv_if(k < 3, 32'(k * 4));
            @(negedge clk);
            if (k < 3) chk($sformatf("fetch%0d_ready", k), bus.if_req_ready, 1'b1);
            if (k > 0) begin
                chk($sformatf("fetch%0d_rsp", k), bus.if_rsp_valid, 1'b1);
                chk($sformatf("fetch%0d_rdata", k), bus.if_rdata,
                    32'hA000_0000 + 32'(k - 1));
            end
        end

        // Conflict: fetch wins after four consecutive losses
        for (int k = 0; k < 10; k++) begin
            step();
            drv_if(1'b1, 32'h20);
            drv_ls(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
            @(negedge clk);
            chk($sformatf("conflict%0d_gnt", k),
                {bus.if_req_ready, bus.ls_req_ready},
                (k == 4 || k == 9) ? 32'h2 : 32'h1);
        end
        step();
        drv_if(1'b0, 32'h0);
        drv_ls(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Out-of-range store must not touch the array
        step();
        drv_ls(1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        chk("range_accept", {bus.ls_req_ready, bus.mem_en, bus.mem_we}, 32'h4);
        step();
        drv_ls(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("range_rsp", {bus.ls_rsp_valid, bus.ls_err, bus.if_rsp_valid}, 32'h6);
        chk("range_rdata", bus.ls_rdata, 32'h0);
        chk("range_mem0", mem[0], 32'hA000_0000);

        // Store then load on the deep instance
        step();
        drv_ls2(1'b1, 1'b1, 32'h1008, 32'h4040_0000, 4'hF);
        @(negedge clk);
        chk("sl_st_ready", {bus2.ls_req_ready, bus2.mem_we}, 32'h3);
        step();
        drv_ls2(1'b1, 1'b0, 32'h1008, 32'h0, 4'h0);
        @(negedge clk);
        chk("sl_st_ack", {bus2.ls_rsp_valid, bus2.ls_err, bus2.ls_req_ready}, 32'h5);
        chk("sl_st_rdata", bus2.ls_rdata, 32'h0);
        step();
        drv_ls2(1'b1, 1'b1, 32'h1008, 32'hDEAD_BEEF, 4'h5);
        @(negedge clk);
        chk("sl_ld_rdata", bus2.ls_rdata, 32'h4040_0000);
        step();
        drv_ls2(1'b1, 1'b0, 32'h100A, 32'h0, 4'h0);
        step();
        drv_ls2(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk("sl_strb_rdata", bus2.ls_rdata, 32'h40AD_00EF);

        // Reset arriving while a fetch is in flight
        step();
        drv_if(1'b1, 32'h8);
        @(negedge clk);
        chk("mid_issue", bus.if_req_ready, 1'b1);
        step();
        rst = 1'b1;
        drv_if(1'b0, 32'h0);
        @(negedge clk);
        chk("mid_no_rsp", {bus.if_rsp_valid, bus.if_rdata}, 33'h0);
        step();
        rst = 1'b0;
        drv_if(1'b1, 32'h14);
        step();
        drv_if(1'b0, 32'h0);
        @(negedge clk);
        chk("mid_after_rsp", bus.if_rsp_valid, 1'b1);
        chk("mid_after_rdata", bus.if_rdata, 32'hA000_0005);

        // Randomized traffic against the reference model
        step();
        rst = 1'b1;
        init_mem = 1'b1;
        step();
        step();
        rst = 1'b0;
        init_mem = 1'b0;
        for (int i = 0; i < W; i++) ref_mem[i] = 32'hA000_0000 + 32'(i);
        starve = 0;
        iv = 1'b0; lv = 1'b0; lwe = 1'b0;
        ia = '0; la = '0; lwd = '0; lws = '0;
        if_acc = 1'b0; ls_acc = 1'b0;
        p_if = 1'b0; p_ls = 1'b0; p_err = 1'b0; p_data = '0;
        for (int c = 0; c <= NR; c++) begin
            step();
            if (!iv || if_acc) begin
                iv = ($urandom_range(0, 3) != 0);
                ia = rnd_addr();
            end
            if (!lv || ls_acc) begin
                lv  = ($urandom_range(0, 2) != 0);
                lwe = $urandom_range(0, 1) == 1;
                la  = rnd_addr();
                lwd = $urandom();
                lws = 4'($urandom_range(0, 15));
            end
            if (c == NR) begin
                iv = 1'b0;
                lv = 1'b0;
            end
            drv_if(iv, ia);
            drv_ls(lv, lwe, la, lwd, lws);
            @(negedge clk);
            eg_if = iv && (!lv || starve == SL);
            eg_ls = lv && !eg_if;
            chk("rnd_grant", {bus.if_req_ready, bus.ls_req_ready}, {eg_if, eg_ls});
            chk("rnd_rsp",
                {bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_err, bus.ls_err},
                {p_if, p_ls, p_if && p_err, p_ls && p_err});
            chk("rnd_if_rdata", bus.if_rdata, p_if ? p_data : 32'h0);
            chk("rnd_ls_rdata", bus.ls_rdata, p_ls ? p_data : 32'h0);
            if (eg_if) starve = 0;
            else if (iv && eg_ls && starve < SL) starve++;
            a      = eg_if ? ia : la;
            p_if   = eg_if;
            p_ls   = eg_ls;
            p_err  = (a >> 2) >= W;
            p_data = '0;
            if ((eg_if || eg_ls) && !p_err) begin
                idx = int'(a >> 2);
                if (eg_ls && lwe) begin
                    for (int b = 0; b < 4; b++)
                        if (lws[b]) ref_mem[idx][8*b +: 8] = lwd[8*b +: 8];
                end else begin
                    p_data = ref_mem[idx];
                end
            end
            if_acc = eg_if;
            ls_acc = eg_ls;
        end
        bad = 0;
        for (int i = 0; i < W; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("rnd_mem_final", 32'(bad), 32'h0);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
